// File: rtl/micro_fetch.sv
// Microprogram fetch stage: walks a synchronous microcode ROM and hands words to decode.
// Optional delayed-branch support (one delay slot, one squash bubble) is enabled by MICRO_FETCH_BRANCH_EN.
module micro_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic [10:0] data_addr_base,
  input  logic        stall,
  input  logic        jump,
  input  logic [7:0]  jump_addr,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [32:0] rom_data,
  output logic [32:0] micro_instr_out,
  output logic [10:0] data_address_out,
  output logic        valid_out,
  output logic        halted
);

  localparam logic [32:0] HALT_WORD = 33'h1_FFFF_FFFF;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  upc;
  logic [10:0] cnt;
  logic        squash;
  logic        load, advance, issue, halt_hit, take_jump;

  function automatic logic is_halt_word(input logic [32:0] w);
    return w == HALT_WORD;
  endfunction

  assign rom_addr = upc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    issue     = 1'b0;
    halt_hit  = 1'b0;
    take_jump = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        rom_en = !stall;
        if (!stall) state_nxt = RUN;
      end
      RUN: begin
        rom_en  = !stall;
        advance = !stall;
        // The word behind a taken branch is dropped, even if it is the halt sentinel.
        if (!stall && !squash) begin
          if (is_halt_word(rom_data)) begin
            halt_hit  = 1'b1;
            state_nxt = HALT;
          end else begin
            issue = 1'b1;
          end
        end
`ifdef MICRO_FETCH_BRANCH_EN
        take_jump = !stall && jump && !halt_hit;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef MICRO_FETCH_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{jump, jump_addr};
`endif

  // Fetch/issue stage: uPC feeds the ROM, ROM word lands on the decode outputs one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc              <= '0;
      cnt              <= '0;
      squash           <= 1'b0;
      micro_instr_out  <= '0;
      data_address_out <= '0;
      valid_out        <= 1'b0;
      halted           <= 1'b0;
    end else begin
      if (load)           upc <= start_addr;
      else if (take_jump) upc <= jump_addr;
      else if (rom_en)    upc <= upc + 8'd1;

      if (load)       cnt <= data_addr_base;
      else if (issue) cnt <= cnt + 11'd1;

      if (issue) begin
        micro_instr_out  <= rom_data;
        data_address_out <= cnt;
      end

      if (advance) begin
        valid_out <= issue;
        squash    <= take_jump;
      end

      if (halt_hit)  halted <= 1'b1;
      else if (load) halted <= 1'b0;
    end
  end

endmodule

// File: doc/micro_fetch.md
MICRO_FETCH -- requirements
Module: micro_fetch

Interface
REQ-001 The block SHALL use these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch/relaunch pulse.
- start_addr  in  8  first microinstruction ROM address.
- data_addr_base  in  11  initial data address.
- stall  in  1  downstream hold request.
- jump  in  1  branch request.
- jump_addr  in  8  branch target address.
- rom_addr  out  8  microprogram ROM address, equal to the internal uPC.
- rom_en  out  1  ROM read/clock enable.
- rom_data  in  33  synchronous ROM word, valid one enabled cycle after rom_addr.
- micro_instr_out  out  33  registered microinstruction to the decode stage.
- data_address_out  out  11  registered data address to the decode stage.
- valid_out  out  1  outputs carry a live microinstruction.
- halted  out  1  halt sentinel reached.

Function
REQ-002 The block SHALL implement a four-state FSM: IDLE, PRIME, RUN, HALT.
REQ-003 In IDLE, a start pulse SHALL load uPC with start_addr and the data-address counter with data_addr_base, then move to PRIME.
REQ-004 In PRIME, rom_en SHALL be 1 for exactly one cycle; valid_out SHALL stay 0; the uPC SHALL increment; next state SHALL be RUN.
REQ-005 In RUN with stall=0, each cycle SHALL:
- capture rom_data into micro_instr_out;
- drive data_address_out from the counter;
- assert valid_out;
- increment the uPC and the data-address counter.
REQ-006 rom_en SHALL equal (state is PRIME or RUN) AND NOT stall.
REQ-007 While stall=1, uPC, counter, micro_instr_out, data_address_out and valid_out SHALL hold, and no ROM word SHALL be lost or duplicated.
REQ-008 The uPC SHALL wrap 8'hFF to 8'h00; the data-address counter SHALL wrap 11'h7FF to 11'h000.
REQ-009 When jump=1 in RUN with stall=0 at cycle t:
- the uPC SHALL load jump_addr;
- the word captured at the end of t SHALL still issue (one delay slot);
- the ROM word presented at t+1 SHALL be squashed (valid_out=0 at t+2, counter not incremented);
- ROM[jump_addr] SHALL appear on micro_instr_out at t+3.
REQ-010 jump asserted together with stall=1 SHALL be ignored; jump outside RUN SHALL be ignored.
REQ-011 A captured rom_data equal to 33'h1_FFFF_FFFF (halt sentinel) SHALL NOT be issued: valid_out=0, state moves to HALT, halted=1.
REQ-012 In HALT, all outputs SHALL hold and rom_en SHALL be 0; start SHALL clear halted and behave as in IDLE.
REQ-013 start in PRIME or RUN SHALL be ignored.
REQ-014 A halt sentinel arriving in the jump squash slot SHALL be discarded without halting.

Reset
REQ-015 reset_n=0 SHALL immediately, regardless of clk, force:
- state IDLE;
- uPC 0, counter 0;
- rom_addr 0, rom_en 0;
- micro_instr_out 0, data_address_out 0;
- valid_out 0, halted 0.
REQ-016 Reset asserted mid-RUN, mid-stall or mid-jump SHALL abandon any in-flight word; after release the block SHALL remain in IDLE until start.

Configuration
REQ-017 Branch support SHALL be controlled by macro MICRO_FETCH_BRANCH_EN.
- Defined: REQ-009, REQ-010 and REQ-014 apply.
- Undefined: jump and jump_addr are present but ignored, with no squash cycle.

Verification
REQ-018 Reset/launch: start_addr=8'h10, ROM[10..12]=A,B,C, no stall -> valid_out rises 3 cycles after start; A, B, C on consecutive cycles; data_address_out = base, base+1, base+2.
REQ-019 Stall: 2-cycle stall while B is on the output -> B held 2 extra cycles, then C; no loss or duplication.
REQ-020 Jump: jump to 8'h40 while B is on the output -> C issues, one valid_out=0 bubble, then ROM[40]; counter skips the bubble.
REQ-021 Wrap/halt: start_addr=8'hFE with ROM[00]=33'h1_FFFF_FFFF -> ROM[FE], ROM[FF] issue, then halted=1 and valid_out=0; start restarts.
REQ-022 Async reset pulse mid-RUN between clock edges -> outputs zero immediately; block stays in IDLE until start.
REQ-023 Macro undefined: the REQ-020 stimulus -> sequential issue continues with no bubble.
